// File: rtl/fpu_wb_pkg.sv
// Shared types for the FPU writeback path: fflags bit positions, the buffered
// result entry and the fpnew status-to-fflags mapping.
package fpu_wb_pkg;

  localparam int unsigned NUM_FFLAGS = 5;
  localparam int unsigned FFLAG_NV   = 4;
  localparam int unsigned FFLAG_DZ   = 3;
  localparam int unsigned FFLAG_OF   = 2;
  localparam int unsigned FFLAG_UF   = 1;
  localparam int unsigned FFLAG_NX   = 0;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_TAG_W  = 5;

  typedef logic [NUM_FFLAGS-1:0] fflags_t;

  // Same field order as fpnew_pkg::status_t
  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } fpnew_status_t;

  typedef struct packed {
    logic [WB_DATA_W-1:0]  data;
    logic [NUM_FFLAGS-1:0] status;
    logic [WB_TAG_W-1:0]   tag;
  } wb_entry_t;

  function automatic fflags_t status_to_fflags(input fpnew_status_t s);
    fflags_t f;
    f           = '0;
    f[FFLAG_NV] = s.NV;
    f[FFLAG_DZ] = s.DZ;
    f[FFLAG_OF] = s.OF;
    f[FFLAG_UF] = s.UF;
    f[FFLAG_NX] = s.NX;
    return f;
  endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Generic Depth x EntryW FIFO with separate occupancy count and synchronous flush.
// Head data reads as zero while empty.
module fpu_wb_fifo #(
  parameter  int unsigned EntryW = 42,
  parameter  int unsigned Depth  = 2,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned CntW   = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [EntryW-1:0] wdata_i,
  input  logic              pop_i,
  output logic [EntryW-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CntW-1:0]   count_o
);

  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [EntryW-1:0] mem_q [Depth];
  logic [PtrW-1:0]   wptr_q;
  logic [PtrW-1:0]   rptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);

  // Flush wins over any handshake in the same cycle
  assign do_push = push_i && !full_o  && !flush_i;
  assign do_pop  = pop_i  && !empty_o && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= FullCnt);

endmodule

// File: rtl/fpu_result_collector.sv
// Buffers fpnew results and presents them on a register-file writeback port,
// accruing sticky fcsr exception flags as entries retire.
module fpu_result_collector
  import fpu_wb_pkg::*;
#(
  parameter  int unsigned Width    = 32,
  parameter  int unsigned TagWidth = 5,
  parameter  int unsigned Depth    = 2,
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  fpu_valid_i,
  output logic                  fpu_ready_o,
  input  logic [Width-1:0]      fpu_result_i,
  input  logic [NUM_FFLAGS-1:0] fpu_status_i,
  input  logic [TagWidth-1:0]   fpu_tag_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [Width-1:0]      wb_data_o,
  output logic [TagWidth-1:0]   wb_rd_o,
  output logic [NUM_FFLAGS-1:0] wb_status_o,
  output logic [NUM_FFLAGS-1:0] fflags_o,
  input  logic                  fflags_clr_i,
  output logic [CntW-1:0]       count_o,
  output logic                  busy_o
);

  localparam int unsigned EntryW = Width + NUM_FFLAGS + TagWidth;

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [EntryW-1:0] wdata;
  logic [EntryW-1:0] rdata;
  fflags_t           status_vec;
  fflags_t           fflags_q;
  fflags_t           fflags_d;

  assign status_vec = status_to_fflags(fpnew_status_t'(fpu_status_i));
  assign wdata      = {fpu_result_i, status_vec, fpu_tag_i};

  // No push-on-pop when full: ready depends only on registered occupancy
  assign fpu_ready_o = !full;
  assign push        = fpu_valid_i && fpu_ready_o;
  assign wb_valid_o  = !empty;
  assign pop         = wb_valid_o && wb_ready_i;
  assign busy_o      = !empty;

  fpu_wb_fifo #(
    .EntryW (EntryW),
    .Depth  (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

  assign {wb_data_o, wb_status_o, wb_rd_o} = rdata;

  // A retiring entry's flags survive a same-cycle clear; a flushed pop never retires
  always_comb begin
    fflags_d = fflags_clr_i ? '0 : fflags_q;
    if (pop && !flush_i) fflags_d = fflags_d | wb_status_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fflags_q <= '0;
    else         fflags_q <= fflags_d;
  end

  assign fflags_o = fflags_q;

  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fpu_valid_i && !fpu_ready_o) |=>
      ($stable(fpu_result_i) && $stable(fpu_status_i) && $stable(fpu_tag_i)));

endmodule

// File: tb/tb_fpu_result_collector.sv
// Bench for fpu_result_collector: directed vector table, reset/wrap sequences,
// then randomized traffic against a queue-based reference model.
module tb_fpu_result_collector;
  import fpu_wb_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 5;
  localparam int unsigned D  = 2;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          fpu_valid_i;
  logic          fpu_ready_o;
  logic [W-1:0]  fpu_result_i;
  logic [4:0]    fpu_status_i;
  logic [TW-1:0] fpu_tag_i;
  logic          wb_valid_o;
  logic          wb_ready_i;
  logic [W-1:0]  wb_data_o;
  logic [TW-1:0] wb_rd_o;
  logic [4:0]    wb_status_o;
  logic [4:0]    fflags_o;
  logic          fflags_clr_i;
  logic [CW-1:0] count_o;
  logic          busy_o;

  fpu_result_collector #(.Width(W), .TagWidth(TW), .Depth(D)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .fpu_valid_i  (fpu_valid_i),
    .fpu_ready_o  (fpu_ready_o),
    .fpu_result_i (fpu_result_i),
    .fpu_status_i (fpu_status_i),
    .fpu_tag_i    (fpu_tag_i),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .wb_data_o    (wb_data_o),
    .wb_rd_o      (wb_rd_o),
    .wb_status_o  (wb_status_o),
    .fflags_o     (fflags_o),
    .fflags_clr_i (fflags_clr_i),
    .count_o      (count_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic [4:0]  st;
    logic [4:0]  tag;
    logic        wbr;
    logic        clr;
    logic        fl;
    logic [1:0]  e_cnt;
    logic        e_wbv;
    logic        e_rdy;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic [4:0]  e_ff;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] st,
                       input logic [4:0] tag, input logic wbr, input logic clr, input logic fl);
    fpu_valid_i  = v;
    fpu_result_i = res;
    fpu_status_i = st;
    fpu_tag_i    = tag;
    wb_ready_i   = wbr;
    fflags_clr_i = clr;
    flush_i      = fl;
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] res, input logic [4:0] st,
                              input logic [4:0] tag, input logic wbr, input logic clr,
                              input logic fl, input logic [1:0] cnt, input logic wbv,
                              input logic rdy, input logic [31:0] d, input logic [4:0] rd,
                              input logic [4:0] ff);
    vec_t r;
    r.v = v; r.res = res; r.st = st; r.tag = tag; r.wbr = wbr; r.clr = clr; r.fl = fl;
    r.e_cnt = cnt; r.e_wbv = wbv; r.e_rdy = rdy; r.e_data = d; r.e_rd = rd; r.e_ff = ff;
    return r;
  endfunction

  wb_entry_t   mq[$];
  logic [4:0]  mff;
  logic        o_v;
  logic [31:0] o_res;
  logic [4:0]  o_st;
  logic [4:0]  o_tag;
  logic        r_wbr, r_clr, r_fl;
  logic        last_acc;
  logic        acc, popp;
  logic [4:0]  nff;

  initial begin
    rst_ni = 1'b0;
    drive(0, 32'h0, 5'h0, 5'h0, 0, 0, 0);
    #12;
    chk("rst_count", count_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_fflags", fflags_o, 0);
    chk("rst_ready", fpu_ready_o, 1);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_wb_rd", wb_rd_o, 0);
    chk("rst_wb_status", wb_status_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    //           v  res           st     tag    wbr clr fl | cnt wbv rdy data          rd     ff
    tbl.push_back(mk(1, 32'h40400000, 5'h00, 5'd5,  1, 0, 0,  2'd1, 1, 1, 32'h40400000, 5'd5,  5'h00));
    tbl.push_back(mk(0, 32'h0,        5'h00, 5'd0,  1, 0, 0,  2'd0, 0, 1, 32'h0,        5'd0,  5'h00));
    tbl.push_back(mk(1, 32'h11111111, 5'h00, 5'd1,  0, 0, 0,  2'd1, 1, 1, 32'h11111111, 5'd1,  5'h00));
    tbl.push_back(mk(1, 32'h22222222, 5'h00, 5'd2,  0, 0, 0,  2'd2, 1, 0, 32'h11111111, 5'd1,  5'h00));
    tbl.push_back(mk(1, 32'h33333333, 5'h00, 5'd3,  0, 0, 0,  2'd2, 1, 0, 32'h11111111, 5'd1,  5'h00));
    tbl.push_back(mk(1, 32'h33333333, 5'h00, 5'd3,  1, 0, 0,  2'd1, 1, 1, 32'h22222222, 5'd2,  5'h00));
    tbl.push_back(mk(1, 32'h33333333, 5'h00, 5'd3,  1, 0, 0,  2'd1, 1, 1, 32'h33333333, 5'd3,  5'h00));
    tbl.push_back(mk(0, 32'h0,        5'h00, 5'd0,  1, 0, 0,  2'd0, 0, 1, 32'h0,        5'd0,  5'h00));
    tbl.push_back(mk(1, 32'h7F800000, 5'h05, 5'd7,  0, 0, 0,  2'd1, 1, 1, 32'h7F800000, 5'd7,  5'h00));
    tbl.push_back(mk(0, 32'h0,        5'h00, 5'd0,  1, 0, 0,  2'd0, 0, 1, 32'h0,        5'd0,  5'h05));
    tbl.push_back(mk(1, 32'h7FC00000, 5'h10, 5'd8,  0, 0, 0,  2'd1, 1, 1, 32'h7FC00000, 5'd8,  5'h05));
    tbl.push_back(mk(0, 32'h0,        5'h00, 5'd0,  1, 0, 0,  2'd0, 0, 1, 32'h0,        5'd0,  5'h15));
    tbl.push_back(mk(1, 32'h3F800000, 5'h01, 5'd9,  0, 0, 0,  2'd1, 1, 1, 32'h3F800000, 5'd9,  5'h15));
    tbl.push_back(mk(0, 32'h0,        5'h00, 5'd0,  1, 1, 0,  2'd0, 0, 1, 32'h0,        5'd0,  5'h01));
    tbl.push_back(mk(1, 32'hAAAA0000, 5'h08, 5'd10, 0, 0, 0,  2'd1, 1, 1, 32'hAAAA0000, 5'd10, 5'h01));
    tbl.push_back(mk(1, 32'hBBBB0000, 5'h02, 5'd11, 0, 0, 0,  2'd2, 1, 0, 32'hAAAA0000, 5'd10, 5'h01));
    tbl.push_back(mk(1, 32'hCCCC0000, 5'h04, 5'd12, 1, 0, 1,  2'd0, 0, 1, 32'h0,        5'd0,  5'h01));
    tbl.push_back(mk(0, 32'hCCCC0000, 5'h04, 5'd12, 0, 1, 0,  2'd0, 0, 1, 32'h0,        5'd0,  5'h00));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].res, tbl[i].st, tbl[i].tag, tbl[i].wbr, tbl[i].clr, tbl[i].fl);
      step();
      chk($sformatf("vec%0d_count", i), count_o, tbl[i].e_cnt);
      chk($sformatf("vec%0d_wb_valid", i), wb_valid_o, tbl[i].e_wbv);
      chk($sformatf("vec%0d_busy", i), busy_o, tbl[i].e_wbv);
      chk($sformatf("vec%0d_ready", i), fpu_ready_o, tbl[i].e_rdy);
      chk($sformatf("vec%0d_wb_data", i), wb_data_o, tbl[i].e_data);
      chk($sformatf("vec%0d_wb_rd", i), wb_rd_o, tbl[i].e_rd);
      chk($sformatf("vec%0d_fflags", i), fflags_o, tbl[i].e_ff);
    end

    // Asynchronous reset with one entry buffered and nonzero flags
    drive(1, 32'h12345678, 5'h10, 5'd3, 0, 0, 0); step();
    drive(0, 32'h0, 5'h00, 5'd0, 1, 0, 0);        step();
    drive(1, 32'h87654321, 5'h00, 5'd4, 0, 0, 0); step();
    drive(0, 32'h0, 5'h00, 5'd0, 0, 0, 0);
    chk("arst_pre_count", count_o, 1);
    chk("arst_pre_fflags", fflags_o, 5'h10);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_count", count_o, 0);
    chk("arst_wb_valid", wb_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_ready", fpu_ready_o, 1);
    chk("arst_wb_data", wb_data_o, 0);
    chk("arst_wb_rd", wb_rd_o, 0);
    chk("arst_fflags", fflags_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Streaming push/pop through pointer wrap, then a full fill and drain
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'hD0000000 + k, 5'h00, 5'(20 + k), 1, 0, 0);
      step();
      chk($sformatf("wrap%0d_count", k), count_o, 1);
      chk($sformatf("wrap%0d_data", k), wb_data_o, 32'hD0000000 + k);
      chk($sformatf("wrap%0d_rd", k), wb_rd_o, 20 + k);
    end
    drive(0, 32'h0, 5'h00, 5'd0, 1, 0, 0); step();
    chk("wrap_drain_count", count_o, 0);
    drive(1, 32'hE0000000, 5'h00, 5'd1, 0, 0, 0); step();
    drive(1, 32'hE0000001, 5'h00, 5'd2, 0, 0, 0); step();
    chk("wrapfull_count", count_o, 2);
    chk("wrapfull_ready", fpu_ready_o, 0);
    drive(0, 32'hE0000001, 5'h00, 5'd2, 1, 0, 0);
    chk("wrapfull_head0", wb_data_o, 32'hE0000000);
    step();
    chk("wrapfull_head1", wb_data_o, 32'hE0000001);
    step();
    chk("wrapfull_empty", wb_valid_o, 0);

    // Randomized traffic against the queue model
    mq.delete();
    mff      = 5'h00;
    last_acc = 1'b1;
    o_v      = 1'b0;
    o_res    = '0;
    o_st     = '0;
    o_tag    = '0;
    for (int c = 0; c < 500; c++) begin
      chk("rnd_count", count_o, mq.size());
      chk("rnd_wb_valid", wb_valid_o, mq.size() != 0);
      chk("rnd_ready", fpu_ready_o, mq.size() < D);
      chk("rnd_fflags", fflags_o, mff);
      if (mq.size() != 0) begin
        chk("rnd_wb_data", wb_data_o, mq[0].data);
        chk("rnd_wb_rd", wb_rd_o, mq[0].tag);
        chk("rnd_wb_status", wb_status_o, mq[0].status);
      end else begin
        chk("rnd_wb_data_empty", wb_data_o, 0);
      end

      if (!o_v || last_acc) begin
        o_v   = ($urandom_range(0, 3) != 0);
        o_res = $urandom;
        o_st  = 5'($urandom_range(0, 31));
        o_tag = 5'($urandom_range(0, 31));
      end
      r_wbr = ($urandom_range(0, 1) != 0);
      r_clr = ($urandom_range(0, 15) == 0);
      r_fl  = ($urandom_range(0, 31) == 0);
      drive(o_v, o_res, o_st, o_tag, r_wbr, r_clr, r_fl);

      acc  = o_v && (mq.size() < D);
      popp = r_wbr && (mq.size() > 0);
      nff  = r_clr ? 5'h00 : mff;
      if (r_fl) begin
        mq.delete();
      end else begin
        if (popp) begin
          nff = nff | mq[0].status;
          void'(mq.pop_front());
        end
        if (acc) mq.push_back('{data: o_res, status: o_st, tag: o_tag});
      end
      mff      = nff;
      last_acc = acc;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
